serial_add8: RTL

SERIAL_ADD8 -- requirements
Module: serial_add8

---
 rtl/serial_add8.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/serial_add8.sv
// -----------------------------------------------------------------------------
// serial_add8 -- bit-serial adder with a valid/ready handshake on each side.
//
// An operand pair is accepted in IDLE. The pair is added one bit per clock,
// LSB first, over WIDTH RUN cycles. The result is then held in DONE until the
// downstream side accepts it. The result registers keep their value after
// the return to IDLE, until the next operand pair is accepted.
//
// Optional feature: define SERIAL_ADD8_OVF_EN to build the signed overflow
// detector. Without the macro, out_ovf is tied to 0 and no overflow logic
// is built.
//
// Parameters:
//   WIDTH      operand width in bits (2..16), default 8
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair presented
//   in_ready   block can accept an operand pair (IDLE only)
//   in_a       operand A
//   in_b       operand B
//   out_valid  result held and presented (DONE only)
//   out_ready  downstream accepts the result
//   out_sum    (A + B) mod 2^WIDTH
//   out_cout   carry out of the MSB
//   out_ovf    signed overflow flag (0 unless SERIAL_ADD8_OVF_EN)
//   busy       high in RUN or DONE
// -----------------------------------------------------------------------------
module serial_add8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last_bit;

  // One full adder built from two cascaded half adders on the current LSBs.
  logic             w_ha0_s;
  logic             w_ha0_c;
  logic             w_ha1_c;
  logic             w_s;
  logic             w_c;

  assign w_ha0_s    = r_a[0] ^ r_b[0];
  assign w_ha0_c    = r_a[0] & r_b[0];
  assign w_s        = w_ha0_s ^ r_carry;
  assign w_ha1_c    = w_ha0_s & r_carry;
  assign w_c        = w_ha0_c | w_ha1_c;

  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last_bit) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // Leaving DONE goes to IDLE, so no new pair can be taken on this edge.
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, sum shifter, carry and bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      // Each new sum bit enters at the MSB. After WIDTH shifts, bit 0 of the
      // sum has reached position 0.
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_c;
      // The counter stops at WIDTH-1. The FSM leaves RUN on that same edge.
      if (!w_last_bit) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign out_sum  = r_sum;
  assign out_cout = r_carry;

`ifdef SERIAL_ADD8_OVF_EN
  // On the last bit cycle, r_a[0] and r_b[0] hold the latched operand MSBs,
  // and w_s is the sum MSB. The flag is registered on the same edge that
  // enters DONE.
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_last_bit) begin
      r_ovf <= (r_a[0] == r_b[0]) & (w_s != r_a[0]);
    end
  end

  assign out_ovf = r_ovf;
`else
  assign out_ovf = 1'b0;
`endif

endmodule
